// File: rtl/palu_stim_driver.sv
// Initiator for the 8-bit parallel ALU: takes single requests or runs a
// 16-vector sweep, holds operands for SETTLE cycles, captures f/ovf and
// returns them through a valid/ready response port.
module palu_stim_driver #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       sweep_start,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [7:0] alu_f,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_f,
  output logic       rsp_ovf,
  output logic [1:0] rsp_sel,
  output logic [3:0] rsp_idx,
  output logic       rsp_sweep,
  output logic       busy,
  output logic       sweep_done
);

  typedef enum logic [1:0] {IDLE, SETTLE_ST, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic       sweep;
  logic [3:0] nxt_idx;

  // Sweep operand table, indexed by the low two bits of the vector index.
  function automatic logic [7:0] vec_a(input logic [1:0] i);
    case (i)
      2'd0:    vec_a = 8'h0F;
      2'd1:    vec_a = 8'hF0;
      2'd2:    vec_a = 8'h0F;
      default: vec_a = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] vec_b(input logic [1:0] i);
    case (i)
      2'd0:    vec_b = 8'h0F;
      2'd1:    vec_b = 8'h0F;
      2'd2:    vec_b = 8'hF0;
      default: vec_b = 8'hFF;
    endcase
  endfunction

  assign nxt_idx = idx + 4'd1;

  // Handshake/status outputs are forced low while reset is asserted.
  assign req_ready = (state == IDLE) && !rst && !sweep_start;
  assign busy      = (state != IDLE) && !rst;

  // Main control FSM: load operands, wait settle time, present response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx        <= 4'd0;
      sweep      <= 1'b0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_sel    <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_f      <= 8'd0;
      rsp_ovf    <= 1'b0;
      rsp_sel    <= 2'd0;
      rsp_idx    <= 4'd0;
      rsp_sweep  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          // sweep_start wins over a pending request
          if (sweep_start) begin
            alu_a   <= vec_a(2'd0);
            alu_b   <= vec_b(2'd0);
            alu_sel <= 2'd0;
            idx     <= 4'd0;
            sweep   <= 1'b1;
            cnt     <= 4'd0;
            state   <= SETTLE_ST;
          end else if (req_valid) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_sel;
            idx     <= 4'd0;
            sweep   <= 1'b0;
            cnt     <= 4'd0;
            state   <= SETTLE_ST;
          end
        end
        SETTLE_ST: begin
          if (cnt == 4'(SETTLE - 1)) begin
            rsp_f     <= alu_f;
            rsp_ovf   <= alu_ovf;
            rsp_sel   <= alu_sel;
            rsp_idx   <= idx;
            rsp_sweep <= sweep;
            rsp_valid <= 1'b1;
            cnt       <= 4'd0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!sweep) begin
              state <= IDLE;
            end else if (idx != 4'd15) begin
              idx     <= nxt_idx;
              alu_a   <= vec_a(nxt_idx[1:0]);
              alu_b   <= vec_b(nxt_idx[1:0]);
              alu_sel <= nxt_idx[3:2];
              cnt     <= 4'd0;
              state   <= SETTLE_ST;
            end else begin
              // last sweep vector: park the ALU inputs at zero
              sweep_done <= 1'b1;
              alu_a      <= 8'd0;
              alu_b      <= 8'd0;
              alu_sel    <= 2'd0;
              sweep      <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palu_stim_driver.sv
// Bench for palu_stim_driver: XOR/AND ALU model, table-driven single
// requests, scoreboard of expected responses, sweep and reset corners.
module tb_palu_stim_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       sweep_start;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_f;
  logic       alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_f;
  logic       rsp_ovf;
  logic [1:0] rsp_sel;
  logic [3:0] rsp_idx;
  logic       rsp_sweep;
  logic       busy;
  logic       sweep_done;

  always #5 clk = ~clk;

  assign alu_f   = alu_a ^ alu_b;
  assign alu_ovf = alu_a[7] & alu_b[7];

  palu_stim_driver #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .sweep_start(sweep_start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_ovf(rsp_ovf), .rsp_sel(rsp_sel),
    .rsp_idx(rsp_idx), .rsp_sweep(rsp_sweep),
    .busy(busy), .sweep_done(sweep_done)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       ovf;
    logic [1:0] sel;
    logic [3:0] idx;
    logic       sweep;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one cycle: wait for the rising edge, then let outputs settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sweep_exp(input logic [3:0] i);
    exp_t       e;
    logic [7:0] a, b;
    case (i[1:0])
      2'd0: begin a = 8'h0F; b = 8'h0F; end
      2'd1: begin a = 8'hF0; b = 8'h0F; end
      2'd2: begin a = 8'h0F; b = 8'hF0; end
      default: begin a = 8'hFF; b = 8'hFF; end
    endcase
    e.f = a ^ b; e.ovf = a[7] & b[7]; e.sel = i[3:2]; e.idx = i; e.sweep = 1'b1;
    return e;
  endfunction

  function automatic exp_t single_exp(input vec_t v);
    exp_t e;
    e.f = v.f; e.ovf = v.ovf; e.sel = v.sel; e.idx = 4'd0; e.sweep = 1'b0;
    return e;
  endfunction

  // Scoreboard monitor: every accepted response is popped and compared.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_f",     32'(rsp_f),     32'(e.f));
        check("rsp_ovf",   32'(rsp_ovf),   32'(e.ovf));
        check("rsp_sel",   32'(rsp_sel),   32'(e.sel));
        check("rsp_idx",   32'(rsp_idx),   32'(e.idx));
        check("rsp_sweep", 32'(rsp_sweep), 32'(e.sweep));
      end
    end
  end

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Runs until sweep_done is seen; reports the cycles spent (or -1).
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int n = 0; n < budget; n++) begin
      step();
      if (sweep_done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  vec_t tbl[5];
  vec_t bp1, bp2;
  int   cyc;
  int   early;

  initial begin
    tbl[0] = '{2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    tbl[1] = '{2'b00, 8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[2] = '{2'b10, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[3] = '{2'b11, 8'hC3, 8'h81, 8'h42, 1'b1};
    tbl[4] = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b0};
    bp1    = '{2'b11, 8'hF0, 8'hF0, 8'h00, 1'b1};
    bp2    = '{2'b10, 8'h12, 8'h34, 8'h26, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_a = 8'd0; req_b = 8'd0;
    sweep_start = 1'b0; rsp_ready = 1'b1;

    // reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_outs", {alu_a, alu_b, alu_sel, rsp_valid, rsp_f, rsp_ovf, sweep_done},
            32'd0);
      check("rst_rsp_meta", {rsp_sel, rsp_idx, rsp_sweep}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy",  32'(busy),      32'd0);

    // table-driven single requests, rsp_ready held high
    for (int i = 0; i < 5; i++) begin
      req_sel = tbl[i].sel; req_a = tbl[i].a; req_b = tbl[i].b; req_valid = 1'b1;
      #1;
      check("single_req_ready", 32'(req_ready), 32'd1);
      sb.push_back(single_exp(tbl[i]));
      step();
      req_valid = 1'b0;
      check("single_alu", {alu_sel, alu_a, alu_b}, {tbl[i].sel, tbl[i].a, tbl[i].b});
      check("single_busy", 32'(busy), 32'd1);
      step();
      check("single_rsp_early", 32'(rsp_valid), 32'd0);
      step();
      check("single_rsp_valid", 32'(rsp_valid), 32'd1);
      step();
      check("single_idle", {busy, rsp_valid, req_ready}, 32'b001);
    end
    wait_empty("single_drain", 10);

    // backpressure: response held 5 cycles, second request refused meanwhile
    rsp_ready = 1'b0;
    req_sel = bp1.sel; req_a = bp1.a; req_b = bp1.b; req_valid = 1'b1;
    sb.push_back(single_exp(bp1));
    step();
    req_sel = bp2.sel; req_a = bp2.a; req_b = bp2.b;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_hold", {rsp_valid, rsp_f, rsp_ovf, rsp_sel}, {1'b1, bp1.f, bp1.ovf, bp1.sel});
      check("bp_req_ready", 32'(req_ready), 32'd0);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_back_idle", {busy, req_ready}, 32'b01);
    sb.push_back(single_exp(bp2));
    step();
    req_valid = 1'b0;
    check("bp_second_alu", {alu_sel, alu_a, alu_b}, {bp2.sel, bp2.a, bp2.b});
    wait_empty("bp_drain", 20);
    step();

    // full sweep
    for (int i = 0; i < 16; i++) sb.push_back(sweep_exp(4'(i)));
    sweep_start = 1'b1;
    #1;
    check("sweep_req_ready", 32'(req_ready), 32'd0);
    step();
    sweep_start = 1'b0;
    wait_done(200, cyc);
    check("sweep_done_seen", 32'(cyc >= 0), 32'd1);
    check("sweep_q_empty", 32'(sb.size()), 32'd0);
    check("sweep_alu_zero", {alu_a, alu_b, alu_sel}, 32'd0);
    check("sweep_end_busy", 32'(busy), 32'd0);
    step();
    check("sweep_done_pulse", 32'(sweep_done), 32'd0);

    // sweep_start and req_valid together: sweep first, request afterwards
    req_sel = tbl[3].sel; req_a = tbl[3].a; req_b = tbl[3].b;
    req_valid = 1'b1; sweep_start = 1'b1;
    #1;
    check("sim_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 16; i++) sb.push_back(sweep_exp(4'(i)));
    step();
    sweep_start = 1'b0;
    early = 0;
    cyc = -1;
    for (int n = 0; n < 200; n++) begin
      if (sweep_done === 1'b1) begin
        cyc = n;
        break;
      end
      if (req_ready === 1'b1) early = 1;
      step();
    end
    check("sim_done_seen", 32'(cyc >= 0), 32'd1);
    check("sim_no_early_accept", 32'(early), 32'd0);
    check("sim_ready_after", 32'(req_ready), 32'd1);
    sb.push_back(single_exp(tbl[3]));
    step();
    req_valid = 1'b0;
    check("sim_req_alu", {alu_sel, alu_a, alu_b}, {tbl[3].sel, tbl[3].a, tbl[3].b});
    wait_empty("sim_drain", 20);
    step();

    // reset while the sweep settles on vector 6
    for (int i = 0; i < 6; i++) sb.push_back(sweep_exp(4'(i)));
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    cyc = -1;
    for (int n = 0; n < 100; n++) begin
      step();
      if (sb.size() == 0 && rsp_valid === 1'b0) begin
        cyc = n;
        break;
      end
    end
    check("rst6_reached", 32'(cyc >= 0), 32'd1);
    check("rst6_settle_idx6", {busy, alu_sel, alu_a, alu_b}, {1'b1, 2'b01, 8'h0F, 8'hF0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst6_idle", {busy, req_ready, rsp_valid}, 32'b010);
    check("rst6_alu_zero", {alu_a, alu_b, alu_sel}, 32'd0);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done !== 1'b0 || rsp_valid !== 1'b0) early = 1;
      step();
    end
    check("rst6_no_done", 32'(early), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/palu_stim_driver.md
Name: palu_stim_driver

Overview:
- Initiator side of the 8-bit parallel ALU (`eightbit_palu`) interface.
- Accepts single operation requests through a valid/ready handshake, or runs a built-in 16-vector sweep. It drives a, b and sel into the combinational ALU, waits a programmable settle time, captures f and ovf, and returns them on a valid/ready response port.
- Lets on-chip logic (the lab controller or a self-test) exercise the ALU without a testbench.

Parameters:
- SETTLE, 2, number of cycles the alu_* operands are held stable before f/ovf are captured; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  2  operation select for the request.
- req_a  in  8  operand a.
- req_b  in  8  operand b.
- sweep_start  in  1  start the built-in sweep; sampled only in IDLE.
- alu_a  out  8  registered operand a to the ALU.
- alu_b  out  8  registered operand b to the ALU.
- alu_sel  out  2  registered select to the ALU.
- alu_f  in  8  ALU result.
- alu_ovf  in  1  ALU overflow flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_f  out  8  captured result.
- rsp_ovf  out  1  captured overflow.
- rsp_sel  out  2  select that produced this response.
- rsp_idx  out  4  sweep vector index; 0 for single requests.
- rsp_sweep  out  1  response belongs to a sweep.
- busy  out  1  high whenever state is not IDLE.
- sweep_done  out  1  one-cycle pulse after the 16th sweep response is accepted.

Behaviour:
- Reset, while rst is high at an edge:
  - state becomes IDLE.
  - All registered outputs (alu_*, rsp_*, sweep_done) go to 0.
  - Settle counter and sweep index go to 0.
  - req_ready and busy are 0 during any cycle in which rst is high.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready = !rst && !sweep_start.
  - If sweep_start is high, load vector 0, set the sweep flag and go to SETTLE. sweep_start has priority over req_valid, and no request transfer occurs that cycle.
  - Otherwise, if req_valid && req_ready, load req_sel/req_a/req_b into alu_*, clear the sweep flag, set idx=0 and go to SETTLE.
- SETTLE:
  - Count cycles 0..SETTLE-1.
  - On the last count, register alu_f, alu_ovf, alu_sel, idx and the sweep flag into the rsp_* outputs, set rsp_valid=1 and go to RESP.
- Latency: request accepted at the edge ending cycle T gives:
  - alu_* valid from cycle T+1.
  - rsp_valid high from cycle T+1+SETTLE. With the default SETTLE=2 this is T+3.
- RESP:
  - rsp_* held stable while rsp_ready is low; backpressure is unbounded. req_ready is 0.
  - On rsp_valid && rsp_ready, rsp_valid clears at that edge and:
    - Single request: go to IDLE.
    - Sweep with idx<15: idx+1, load the next vector, go to SETTLE.
    - Sweep with idx==15: pulse sweep_done for one cycle, set alu_a/alu_b/alu_sel to 0, go to IDLE.
- rsp_ready may be high before rsp_valid rises; acceptance occurs in the first cycle rsp_valid is high.
- The minimum request-to-request spacing is SETTLE+2 cycles; there is no pipelining across requests.
- Sweep vector encoding:
  - sel = idx[3:2].
  - Operand pair by idx[1:0]:
    - 0: a=0x0F, b=0x0F
    - 1: a=0xF0, b=0x0F
    - 2: a=0x0F, b=0xF0
    - 3: a=0xFF, b=0xFF
- Reset mid-operation (SETTLE or RESP, single or sweep):
  - The operation is abandoned and the block is in IDLE the next cycle.
  - rsp_valid is 0 and sweep_done is not pulsed.
- sweep_start or req_valid asserted outside IDLE is ignored and does not queue.
- ALU semantics are opaque to this block: f and ovf are captured verbatim.

Test Plan:
- Bench ALU model throughout: alu_f = alu_a ^ alu_b, alu_ovf = alu_a[7] & alu_b[7].
- Reset: rst high 3 cycles → all outputs 0 and req_ready 0 during reset; req_ready=1, busy=0 the first cycle after.
- Single request: sel=01, a=0x0F, b=0xF0, rsp_ready=1, accepted at cycle T → alu_sel/a/b = 01/0F/F0 from T+1; rsp_valid at T+3 with rsp_f=0xFF, rsp_ovf=0, rsp_sel=01, rsp_sweep=0, rsp_idx=0; IDLE at T+4.
- Backpressure: as above with rsp_ready low 5 cycles → rsp_* stable, req_ready 0, a second req_valid not accepted; raising rsp_ready → IDLE next cycle, then the second request is accepted.
- Full sweep, rsp_ready=1:
  - 16 responses with rsp_idx 0..15 in order and rsp_sel = idx[3:2].
  - idx 1: f=0xFF, ovf=0. idx 3: f=0x00, ovf=1.
  - One-cycle sweep_done after the 16th acceptance; alu_* = 0 afterwards.
- Simultaneous sweep_start and req_valid in IDLE → req_ready=0 that cycle and the sweep runs; the pending request is accepted only after sweep_done.
- rst pulse while the sweep is in SETTLE at idx 6 → next cycle IDLE, rsp_valid=0, alu_*=0, no sweep_done pulse.
